seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It shares one combinational bcd_to_7 decoder among NUM_DIGITS digits.
- Drives the decoder's BCD inputs (x1..x4) and gates its segment outputs (A..G) onto the shared segment bus.
- Selects one anode per slot, with a blanking guard between digits.
- Accepts new display values through a valid/ready load handshake, applied tear-free at frame boundaries.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
REFRESH_DIV, 1000, clock cycles each digit is driven (>=1)
BLANK_CYCLES, 2, all-anodes-off cycles before each digit (>=1), for decoder settle and anti-ghosting

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  request to load bcd_in; accepted on a clk edge where load && ready
ready  out  1  high when a new value can be accepted
bcd_in  in  4*NUM_DIGITS  packed digits; bits [3:0] = digit 0 (least significant)
blank_lz  in  1  enable leading-zero blanking; sampled live
x1,x2,x3,x4  out  1 each  BCD to decoder; x1 = MSB
A,B,C,D,E,F,G  in  1 each  segment outputs from decoder, active-high
seg  out  7  {A..G} to display; all 0 when blanked
an  out  NUM_DIGITS  anode enables, active-low; all 1 = display off
frame_tick  out  1  one-cycle pulse when scan wraps from last digit to digit 0

Behaviour:
- Registers:
  - active: displayed digits
  - shadow: pending digits
  - pending flag
  - idx: current digit, 0..NUM_DIGITS-1
  - cnt: slot counter
  - state: BLANK or DRIVE
- Reset (async, rst_n=0):
  - state=BLANK, idx=0, cnt=0, active=0, shadow=0, pending=0.
  - Outputs: ready=1, an=all 1, seg=0, x1..x4=0, frame_tick=0.
  - Reset mid-scan or mid-handshake discards shadow and pending; the display goes dark immediately.
- BLANK state:
  - an=all 1, seg=0.
  - {x1,x2,x3,x4}=active digit idx, so the decoder settles before the digit is driven.
  - Lasts exactly BLANK_CYCLES cycles, with cnt counting 0..BLANK_CYCLES-1.
  - Then enter DRIVE with cnt=0.
- DRIVE state:
  - an[idx]=0, all other anode bits 1.
  - {x1..x4} unchanged from BLANK.
  - seg={A,B,C,D,E,F,G}, unless the digit is suppressed, in which case seg=0.
  - Lasts exactly REFRESH_DIV cycles, then enter BLANK.
  - On that exit, idx increments; NUM_DIGITS-1 wraps to 0.
- Frame period: NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- frame_tick: asserted for the single cycle in which the DRIVE->BLANK transition occurs with idx=NUM_DIGITS-1.
- Suppression, evaluated per digit at drive time. A digit is suppressed if either:
  - its active value is >9 (invalid BCD); or
  - blank_lz=1, i>0, and active digits i..NUM_DIGITS-1 are all 0.
  Digit 0 is never suppressed by leading-zero blanking. Its an bit still goes low; seg=0 only when the digit is invalid.
- Load handshake:
  - Edge with load && ready: shadow<=bcd_in, pending<=1, ready<=0 (next cycle).
  - load while ready=0 is ignored. There is no queueing, and shadow is not overwritten.
- Frame swap:
  - On the frame_tick edge, if pending=1: active<=shadow, pending<=0, ready<=1 from the next cycle.
  - A load and a frame_tick in the same cycle with pending=0 (ready=1): the load is accepted into shadow. It is applied at the next frame_tick, not the current one.
- Worst-case load-to-display latency: one frame plus one cycle.
- active never changes mid-frame; no torn display.
- All outputs except seg are derived from registers only. seg is combinational from A..G gated by state.

Test Plan (bench: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2; frame = 24 cycles):
1. Reset, then release with no load -> ready=1; an sequence per digit is 1111 for 2 cycles then 1110/1101/1011/0111 for 4 cycles; seg=7'b1111110 (digit 0 pattern) while driven; frame_tick every 24 cycles.
2. Load bcd_in=16'h1234 on the cycle after reset release -> ready=0 next cycle; display still 0000 until first frame_tick. Then x1..x4 = 0100/0011/0010/0001 on digits 0..3 and ready=1.
3. Load 16'h0007 with blank_lz=1 -> digits 3,2,1 have seg=0 with their an bit low; digit 0 shows 7. With blank_lz=0 -> digits 1..3 show the 0 pattern.
4. Load 16'h00A5 -> digit 1 (A) seg=0; digits 0/2/3 show 5/0/0 with blank_lz=0.
5. Second load pulse (16'h9999) while ready=0 after loading 16'h1111 -> ignored; after swap active=1111.
6. Assert rst_n=0 mid-DRIVE of digit 2 with pending=1 -> an=1111 and seg=0 immediately; after release ready=1, active=0000, scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display sharing a single external bcd_to_7 decoder. Each digit slot is a
// BLANK guard (anodes off, decoder settling) followed by a DRIVE window. New
// display values arrive through a load/ready handshake into a shadow register
// and are swapped into the active register only at the frame boundary.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   BLANK   | all anodes off, decoder fed the next digit, lasts BLANK_CYCLES
//   DRIVE   | anode idx on, segments gated onto bus, lasts REFRESH_DIV
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    output logic                    ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    blank_lz,
    output logic                    x1,
    output logic                    x2,
    output logic                    x3,
    output logic                    x4,
    input  logic                    A,
    input  logic                    B,
    input  logic                    C,
    input  logic                    D,
    input  logic                    E,
    input  logic                    F,
    input  logic                    G,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pending;

    logic                    blank_done;
    logic                    drive_done;
    logic                    last_digit;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic                    lz_hit;
    logic                    suppress;

    assign blank_done = (state == ST_BLANK) && (cnt == CW'(BLANK_CYCLES - 1));
    assign drive_done = (state == ST_DRIVE) && (cnt == CW'(REFRESH_DIV - 1));
    assign last_digit = (idx == IW'(NUM_DIGITS - 1));

    // Frame boundary: last cycle of the last digit's drive window.
    assign frame_tick = drive_done && last_digit;

    // Slot sequencer: BLANK guard then DRIVE window, advancing idx after each drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (blank_done) begin
                        state <= ST_DRIVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (drive_done) begin
                        state <= ST_BLANK;
                        cnt   <= '0;
                        idx   <= last_digit ? '0 : idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Load handshake into shadow; swap into active only at the frame boundary.
    // ready is the inverse of pending, so a load and a swap never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            ready   <= 1'b1;
        end else if (load && ready) begin
            shadow  <= bcd_in;
            pending <= 1'b1;
            ready   <= 1'b0;
        end else if (frame_tick && pending) begin
            active  <= shadow;
            pending <= 1'b0;
            ready   <= 1'b1;
        end
    end

    // Digit mux and leading-zero detection: upper_zero[i] means digits i..top are all 0.
    always_comb begin
        cur_digit = '0;
        lz_hit    = 1'b0;
        upper_zero[NUM_DIGITS-1] = (active[4*NUM_DIGITS-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (active[i*4 +: 4] == 4'd0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit = active[i*4 +: 4];
            end
        end
        // Digit 0 is never leading-zero blanked, so the scan starts at 1.
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                lz_hit = upper_zero[i];
            end
        end
    end

    assign suppress = (cur_digit > 4'd9) || (blank_lz && lz_hit);

    assign {x1, x2, x3, x4} = cur_digit;

    // Anode decode: only the current digit is pulled low, and only while driving.
    always_comb begin
        an = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((state == ST_DRIVE) && (idx == IW'(i))) begin
                an[i] = 1'b0;
            end
        end
    end

    assign seg = ((state == ST_DRIVE) && !suppress) ? {A, B, C, D, E, F, G} : 7'b0;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a behavioural bcd_to_7 decoder closes the loop,
// a table of display vectors is loaded one after another, and every cycle the
// expected outputs are queued and compared against the sampled DUT outputs.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 2;
    localparam int SL = RD + BC;
    localparam int FR = ND * SL;

    localparam logic [6:0] P0  = 7'b1111110;
    localparam logic [6:0] P1  = 7'b0110000;
    localparam logic [6:0] P2  = 7'b1101101;
    localparam logic [6:0] P3  = 7'b1111001;
    localparam logic [6:0] P4  = 7'b0110011;
    localparam logic [6:0] P5  = 7'b1011011;
    localparam logic [6:0] P6  = 7'b1011111;
    localparam logic [6:0] P7  = 7'b1110000;
    localparam logic [6:0] P8  = 7'b1111111;
    localparam logic [6:0] P9  = 7'b1111011;
    localparam logic [6:0] PX  = 7'b0000001;
    localparam logic [6:0] OFF = 7'b0000000;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic          ready;
    logic [15:0]   bcd_in;
    logic          blank_lz;
    logic          x1, x2, x3, x4;
    logic          A, B, C, D, E, F, G;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          frame_tick;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .ready     (ready),
        .bcd_in    (bcd_in),
        .blank_lz  (blank_lz),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .E         (E),
        .F         (F),
        .G         (G),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External decoder; invalid codes show a dash so gating is observable.
    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: dec = P0;
            4'd1: dec = P1;
            4'd2: dec = P2;
            4'd3: dec = P3;
            4'd4: dec = P4;
            4'd5: dec = P5;
            4'd6: dec = P6;
            4'd7: dec = P7;
            4'd8: dec = P8;
            4'd9: dec = P9;
            default: dec = PX;
        endcase
    endfunction

    assign {A, B, C, D, E, F, G} = dec({x1, x2, x3, x4});

    typedef struct {
        logic [15:0]      bcd;
        logic             blz;
        logic [3:0][6:0]  seg;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [3:0] x;
        logic       tick;
        logic       rdy;
    } obs_t;

    vec_t vecs[8];
    obs_t exp_q[$];

    int pass_cnt;
    int total_cnt;

    int              ph;
    logic [15:0]     m_active;
    logic [15:0]     m_shadow;
    logic            m_pending;
    logic            m_ready;
    int              m_pend_vec;
    logic [3:0][6:0] cur_seg;

    function automatic obs_t model_obs();
        obs_t o;
        int p, d, w;
        p = ph % FR;
        d = p / SL;
        w = p % SL;
        o.an   = (w < BC) ? 4'hF : ~(4'b0001 << d);
        o.seg  = (w < BC) ? OFF : cur_seg[d];
        o.x    = m_active[d*4 +: 4];
        o.tick = (p == FR - 1);
        o.rdy  = m_ready;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.an   = an;
        o.seg  = seg;
        o.x    = {x1, x2, x3, x4};
        o.tick = frame_tick;
        o.rdy  = ready;
        return o;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s ph=%0d: got an=%b seg=%b x=%h tick=%b ready=%b, required an=%b seg=%b x=%h tick=%b ready=%b",
                     name, ph, act.an, act.seg, act.x, act.tick, act.rdy,
                     req.an, req.seg, req.x, req.tick, req.rdy);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, queue the
    // expectation, then compare at the falling edge.
    task automatic cycle(input logic ld, input logic [15:0] val, input string name);
        logic sw;
        sw     = 1'b0;
        load   = ld;
        bcd_in = val;
        if (ld && m_ready) begin
            m_shadow  = val;
            m_pending = 1'b1;
            m_ready   = 1'b0;
        end else if (((ph % FR) == FR - 1) && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
            m_ready   = 1'b1;
            sw        = 1'b1;
        end
        @(posedge clk);
        ph++;
        if (sw) begin
            cur_seg  = vecs[m_pend_vec].seg;
            blank_lz = vecs[m_pend_vec].blz;
        end
        exp_q.push_back(model_obs());
        @(negedge clk);
        load = 1'b0;
        compare(name, dut_obs(), exp_q.pop_front());
    endtask

    // Assert reset at the current falling edge, check the display is dark at
    // once, then release on the next falling edge with the model cleared.
    task automatic reset_release();
        obs_t dark;
        dark.an   = 4'hF;
        dark.seg  = OFF;
        dark.x    = 4'h0;
        dark.tick = 1'b0;
        dark.rdy  = 1'b1;
        rst_n    = 1'b0;
        load     = 1'b0;
        blank_lz = 1'b0;
        #1;
        compare("reset_dark", dut_obs(), dark);
        @(negedge clk);
        rst_n     = 1'b1;
        ph        = 0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
        m_ready   = 1'b1;
        cur_seg   = {P0, P0, P0, P0};
        #1;
        compare("release", dut_obs(), model_obs());
    endtask

    task automatic run_vec(input int i, input logic second_pulse);
        m_pend_vec = i;
        cycle(1'b1, vecs[i].bcd, "load");
        if (second_pulse) begin
            cycle(1'b1, 16'h9999, "ignored_load");
        end
        for (int k = 0; k < 2 * FR; k++) begin
            cycle(1'b0, 16'h0000, "scan");
        end
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        rst_n      = 1'b0;
        load       = 1'b0;
        bcd_in     = '0;
        blank_lz   = 1'b0;
        ph         = 0;
        m_active   = '0;
        m_shadow   = '0;
        m_pending  = 1'b0;
        m_ready    = 1'b1;
        m_pend_vec = 0;
        cur_seg    = {P0, P0, P0, P0};

        vecs[0] = '{16'h1234, 1'b0, {P1,  P2,  P3,  P4}};
        vecs[1] = '{16'h0007, 1'b1, {OFF, OFF, OFF, P7}};
        vecs[2] = '{16'h0007, 1'b0, {P0,  P0,  P0,  P7}};
        vecs[3] = '{16'h00A5, 1'b0, {P0,  P0,  OFF, P5}};
        vecs[4] = '{16'h1111, 1'b0, {P1,  P1,  P1,  P1}};
        vecs[5] = '{16'h0000, 1'b1, {OFF, OFF, OFF, P0}};
        vecs[6] = '{16'h0908, 1'b1, {OFF, P9,  P0,  P8}};
        vecs[7] = '{16'h4321, 1'b0, {P4,  P3,  P2,  P1}};

        repeat (3) @(negedge clk);

        // Idle scan after reset: zeros everywhere, frame_tick every FR cycles.
        reset_release();
        for (int k = 0; k < FR + 4; k++) begin
            cycle(1'b0, 16'h0000, "idle_scan");
        end

        // Load right after release, then the remaining table vectors.
        @(negedge clk);
        reset_release();
        for (int i = 0; i < 7; i++) begin
            run_vec(i, (i == 4));
        end

        // Reset in the middle of digit 2's drive window with a load pending.
        for (int k = 0; k < FR && (ph % FR) != 1; k++) begin
            cycle(1'b0, 16'h0000, "align");
        end
        m_pend_vec = 7;
        cycle(1'b1, vecs[7].bcd, "load_before_reset");
        for (int k = 0; k < FR && (ph % FR) != 2 * SL + BC; k++) begin
            cycle(1'b0, 16'h0000, "to_digit2");
        end
        reset_release();
        for (int k = 0; k < FR + 6; k++) begin
            cycle(1'b0, 16'h0000, "after_reset");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
